pwm_song_sequencer: RTL and testbench

Parametrised, RAM-programmable successor to the fixed-table note sequencer. It plays a song of up to 2**ADDR_W events. Each event is a note code plus a length in ticks, where one tick is TICK_CYCLES clocks. Features: start/stop, loop or one-shot, and a per-note articulation gap. It drives note codes into note_table, which feeds the PWM/phase-accumulator voice, and it replaces hard-coded case tables with host- or ROM-loader-written song memory.

---
 rtl/pwm_song_sequencer_pkg.sv | 25 ++
 rtl/pwm_song_sequencer_timer.sv | 56 +++++
 rtl/pwm_song_sequencer.sv | 120 ++++++++++++
 tb/tb_pwm_song_sequencer.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/pwm_song_sequencer_pkg.sv
// Shared definitions for the song sequencer: FSM state encodings, event field
// widths and the note codes understood by note_table.
package pwm_song_sequencer_pkg;

  typedef enum logic [1:0] {
    SEQ_ST_IDLE = 2'd0,
    SEQ_ST_PLAY = 2'd1,
    SEQ_ST_GAP  = 2'd2,
    SEQ_ST_SKIP = 2'd3
  } seq_state_t;

  localparam int EVT_NOTE_W = 6;
  localparam int EVT_LEN_W  = 8;

  // NOTE_RST is the rest/silence code; the rest are note_table pitch codes.
  localparam logic [EVT_NOTE_W-1:0] NOTE_RST = 6'd0;
  localparam logic [EVT_NOTE_W-1:0] NOTE_C4  = 6'd1;
  localparam logic [EVT_NOTE_W-1:0] NOTE_CS4 = 6'd2;
  localparam logic [EVT_NOTE_W-1:0] NOTE_D4  = 6'd3;
  localparam logic [EVT_NOTE_W-1:0] NOTE_E4  = 6'd5;
  localparam logic [EVT_NOTE_W-1:0] NOTE_FS4 = 6'd7;
  localparam logic [EVT_NOTE_W-1:0] NOTE_A4  = 6'd10;
  localparam logic [EVT_NOTE_W-1:0] NOTE_B4  = 6'd12;

endpackage

// File: rtl/pwm_song_sequencer_timer.sv
// Loadable prescaler plus tick down-counter that times one song slot of
// len*TICK_CYCLES clocks and flags where the articulation gap begins.
module seq_tick_timer #(
  parameter int LEN_W       = 8,
  parameter int TICK_CYCLES = 4,
  parameter int GAP_CYCLES  = 0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             clear,
  input  logic             load,
  input  logic [LEN_W-1:0] len,
  output logic             gap_start,
  output logic             slot_end
);

  localparam int PRE_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [PRE_W-1:0] PRE_TOP = PRE_W'(TICK_CYCLES - 1);
  localparam logic [PRE_W-1:0] PRE_GAP = PRE_W'(GAP_CYCLES);

  generate
    if (TICK_CYCLES < 1 || GAP_CYCLES < 0 || GAP_CYCLES >= TICK_CYCLES) begin : g_bad_timing
      $error("seq_tick_timer: need 0 <= GAP_CYCLES < TICK_CYCLES");
    end
  endgenerate

  logic [PRE_W-1:0] pre;
  logic [LEN_W-1:0] ticks;
  logic             last_tick;

  // The gap occupies the final GAP_CYCLES prescaler counts of the last tick.
  assign last_tick = (ticks == LEN_W'(1));
  assign slot_end  = last_tick && (pre == '0);
  assign gap_start = (GAP_CYCLES != 0) && last_tick && (pre == PRE_GAP);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pre   <= '0;
      ticks <= '0;
    end else if (clear) begin
      pre   <= '0;
      ticks <= '0;
    end else if (load) begin
      pre   <= PRE_TOP;
      ticks <= len;
    end else if (ticks != '0) begin
      if (pre == '0) begin
        ticks <= ticks - LEN_W'(1);
        pre   <= last_tick ? '0 : PRE_TOP;
      end else begin
        pre <= pre - PRE_W'(1);
      end
    end
  end

endmodule

// File: rtl/pwm_song_sequencer.sv
// RAM-programmable song sequencer: steps through note/length events, feeding
// note codes to note_table with optional looping and articulation gaps.
module pwm_song_sequencer
  import pwm_song_sequencer_pkg::*;
#(
  parameter int ADDR_W      = 4,
  parameter int NOTE_W      = EVT_NOTE_W,
  parameter int LEN_W       = EVT_LEN_W,
  parameter int TICK_CYCLES = 2_083_333,
  parameter int GAP_CYCLES  = 0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [NOTE_W-1:0] i_wr_note,
  input  logic [LEN_W-1:0]  i_wr_len,
  input  logic [ADDR_W-1:0] i_last_index,
  input  logic              i_loop,
  input  logic              i_start,
  input  logic              i_stop,
  output logic [NOTE_W-1:0] o_note,
  output logic              o_note_strobe,
  output logic              o_playing,
  output logic [ADDR_W-1:0] o_index,
  output logic              o_done
);

  localparam logic [NOTE_W-1:0] REST_CODE = NOTE_W'(NOTE_RST);

  logic [NOTE_W+LEN_W-1:0] song_mem [2**ADDR_W];

  seq_state_t        state, state_nxt;
  logic [NOTE_W-1:0] ev_note;
  logic [ADDR_W-1:0] rd_addr, adv_idx, idx_nxt;
  logic [NOTE_W-1:0] rd_note;
  logic [LEN_W-1:0]  rd_len;
  logic              load, clear, strobe_nxt, done_nxt;
  logic              gap_start, slot_end;

  always_ff @(posedge i_clk) begin
    if (i_wr_en) song_mem[i_wr_addr] <= {i_wr_note, i_wr_len};
  end

  // Only one slot can be entered per cycle: event 0 on start, else the successor.
  assign adv_idx = (o_index == i_last_index) ? '0 : o_index + ADDR_W'(1);
  assign rd_addr = i_start ? '0 : adv_idx;
  assign {rd_note, rd_len} = song_mem[rd_addr];

  seq_tick_timer #(
    .LEN_W      (LEN_W),
    .TICK_CYCLES(TICK_CYCLES),
    .GAP_CYCLES (GAP_CYCLES)
  ) u_timer (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .clear    (clear),
    .load     (load),
    .len      (rd_len),
    .gap_start(gap_start),
    .slot_end (slot_end)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= SEQ_ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    idx_nxt    = o_index;
    load       = 1'b0;
    clear      = 1'b0;
    strobe_nxt = 1'b0;
    done_nxt   = 1'b0;
    if (i_stop) begin
      state_nxt  = SEQ_ST_IDLE;
      clear      = 1'b1;
      strobe_nxt = (state != SEQ_ST_IDLE);
    end else if (i_start || (state == SEQ_ST_SKIP) ||
                 (slot_end && state != SEQ_ST_IDLE)) begin
      if (!i_start && o_index == i_last_index && !i_loop) begin
        state_nxt  = SEQ_ST_IDLE;
        clear      = 1'b1;
        strobe_nxt = 1'b1;
        done_nxt   = 1'b1;
      end else begin
        state_nxt  = (rd_len == '0) ? SEQ_ST_SKIP : SEQ_ST_PLAY;
        idx_nxt    = rd_addr;
        load       = 1'b1;
        strobe_nxt = 1'b1;
      end
    end else if (state == SEQ_ST_PLAY && gap_start) begin
      state_nxt  = SEQ_ST_GAP;
      strobe_nxt = 1'b1;
    end else if (state == SEQ_ST_IDLE) begin
      clear = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ev_note       <= REST_CODE;
      o_index       <= '0;
      o_note_strobe <= 1'b0;
      o_done        <= 1'b0;
    end else begin
      if (load) ev_note <= rd_note;
      o_index       <= idx_nxt;
      o_note_strobe <= strobe_nxt;
      o_done        <= done_nxt;
    end
  end

  always_comb begin
    o_note    = (state == SEQ_ST_PLAY) ? ev_note : REST_CODE;
    o_playing = (state != SEQ_ST_IDLE);
  end

endmodule

// File: tb/tb_pwm_song_sequencer.sv
// Directed bench for pwm_song_sequencer with a 4-clock tick and 1-clock gap.
module tb_pwm_song_sequencer;
  import pwm_song_sequencer_pkg::*;

  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic       i_wr_en;
  logic [2:0] i_wr_addr;
  logic [5:0] i_wr_note;
  logic [7:0] i_wr_len;
  logic [2:0] i_last_index;
  logic       i_loop;
  logic       i_start;
  logic       i_stop;
  logic [5:0] o_note;
  logic       o_note_strobe;
  logic       o_playing;
  logic [2:0] o_index;
  logic       o_done;

  int vectors  = 0;
  int misses   = 0;

  pwm_song_sequencer #(
    .ADDR_W(3), .NOTE_W(6), .LEN_W(8), .TICK_CYCLES(4), .GAP_CYCLES(1)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr),
    .i_wr_note(i_wr_note), .i_wr_len(i_wr_len), .i_last_index(i_last_index),
    .i_loop(i_loop), .i_start(i_start), .i_stop(i_stop), .o_note(o_note),
    .o_note_strobe(o_note_strobe), .o_playing(o_playing), .o_index(o_index),
    .o_done(o_done)
  );

  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expv);
    vectors++;
    if (got !== expv) begin
      misses++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, expv);
    end
  endtask

  // Drives one cycle of inputs from a negedge and returns on the next negedge.
  task automatic applyStimulus(input logic wr, input logic [2:0] addr, input logic [5:0] note,
                               input logic [7:0] len, input logic start, input logic stop);
    i_wr_en = wr; i_wr_addr = addr; i_wr_note = note; i_wr_len = len;
    i_start = start; i_stop = stop;
    @(negedge i_clk);
    i_wr_en = 1'b0; i_start = 1'b0; i_stop = 1'b0;
  endtask

  // Expected trace of the base song {Cs4,2},{Fs4,1},{RST,1} over cycles 0..15.
  function automatic logic [5:0] song_note(int c);
    if (c < 7)       return NOTE_CS4;
    else if (c == 7) return NOTE_RST;
    else if (c < 11) return NOTE_FS4;
    else             return NOTE_RST;
  endfunction

  function automatic logic [2:0] song_index(int c);
    return (c < 8) ? 3'd0 : (c < 12) ? 3'd1 : 3'd2;
  endfunction

  function automatic logic song_strobe(int c);
    return (c == 0 || c == 7 || c == 8 || c == 11 || c == 12 || c == 15);
  endfunction

  task automatic check_idle(input string tag, input logic strobe);
    checkOutput({tag, " note"}, o_note, NOTE_RST);
    checkOutput({tag, " playing"}, o_playing, 0);
    checkOutput({tag, " done"}, o_done, 0);
    checkOutput({tag, " strobe"}, o_note_strobe, strobe);
  endtask

  initial begin
    i_rst_n = 1'b0; i_wr_en = 0; i_wr_addr = 0; i_wr_note = 0; i_wr_len = 0;
    i_last_index = 3'd2; i_loop = 0; i_start = 0; i_stop = 0;
    repeat (3) @(negedge i_clk);
    check_idle("reset", 1'b0);
    checkOutput("reset index", o_index, 0);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    applyStimulus(1, 3'd0, NOTE_CS4, 8'd2, 0, 0);
    applyStimulus(1, 3'd1, NOTE_FS4, 8'd1, 0, 0);
    applyStimulus(1, 3'd2, NOTE_RST, 8'd1, 0, 0);

    // One-shot playback
    applyStimulus(0, 0, 0, 0, 1, 0);
    for (int c = 0; c < 16; c++) begin
      checkOutput($sformatf("oneshot note c%0d", c), o_note, song_note(c));
      checkOutput($sformatf("oneshot index c%0d", c), o_index, song_index(c));
      checkOutput($sformatf("oneshot strobe c%0d", c), o_note_strobe, song_strobe(c));
      checkOutput($sformatf("oneshot playing c%0d", c), o_playing, 1);
      checkOutput($sformatf("oneshot done c%0d", c), o_done, 0);
      @(negedge i_clk);
    end
    checkOutput("oneshot end done", o_done, 1);
    checkOutput("oneshot end strobe", o_note_strobe, 1);
    checkOutput("oneshot end playing", o_playing, 0);
    checkOutput("oneshot end note", o_note, NOTE_RST);
    checkOutput("oneshot end index", o_index, 2);
    @(negedge i_clk);
    check_idle("oneshot after", 1'b0);

    // Looping over three passes
    i_loop = 1'b1;
    applyStimulus(0, 0, 0, 0, 1, 0);
    for (int c = 0; c < 48; c++) begin
      checkOutput($sformatf("loop note c%0d", c), o_note, song_note(c % 16));
      checkOutput($sformatf("loop index c%0d", c), o_index, song_index(c % 16));
      checkOutput($sformatf("loop strobe c%0d", c), o_note_strobe, song_strobe(c % 16));
      checkOutput($sformatf("loop done c%0d", c), o_done, 0);
      @(negedge i_clk);
    end
    applyStimulus(0, 0, 0, 0, 0, 1);
    check_idle("loop stop", 1'b1);

    // Stop at cycle 5, restart at cycle 10
    applyStimulus(0, 0, 0, 0, 1, 0);
    for (int c = 0; c <= 5; c++) begin
      checkOutput($sformatf("stop note c%0d", c), o_note, NOTE_CS4);
      if (c == 5) i_stop = 1'b1;
      @(negedge i_clk);
    end
    i_stop = 1'b0;
    check_idle("stop c6", 1'b1);
    for (int c = 7; c <= 10; c++) begin
      @(negedge i_clk);
      check_idle($sformatf("stop idle c%0d", c), 1'b0);
    end
    applyStimulus(0, 0, 0, 0, 1, 0);
    for (int c = 11; c <= 18; c++) begin
      checkOutput($sformatf("restart note c%0d", c), o_note, (c < 18) ? NOTE_CS4 : NOTE_RST);
      checkOutput($sformatf("restart index c%0d", c), o_index, 0);
      @(negedge i_clk);
    end
    applyStimulus(0, 0, 0, 0, 1, 1);
    check_idle("start+stop playing", 1'b1);
    applyStimulus(0, 0, 0, 0, 1, 1);
    check_idle("start+stop idle", 1'b0);

    // Asynchronous reset in the middle of event 1
    applyStimulus(0, 0, 0, 0, 1, 0);
    repeat (9) @(negedge i_clk);
    checkOutput("pre-reset index", o_index, 1);
    #2 i_rst_n = 1'b0;
    #1;
    check_idle("async reset", 1'b0);
    checkOutput("async reset index", o_index, 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    check_idle("after reset", 1'b0);

    // Zero-length event becomes a one-cycle skip
    i_loop = 1'b0;
    applyStimulus(1, 3'd1, NOTE_FS4, 8'd0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0);
    for (int c = 0; c < 13; c++) begin
      checkOutput($sformatf("skip note c%0d", c), o_note, (c < 7) ? NOTE_CS4 : NOTE_RST);
      checkOutput($sformatf("skip index c%0d", c), o_index, (c < 8) ? 0 : (c == 8) ? 1 : 2);
      checkOutput($sformatf("skip strobe c%0d", c), o_note_strobe,
                  (c == 0 || c == 7 || c == 8 || c == 9 || c == 12));
      checkOutput($sformatf("skip playing c%0d", c), o_playing, 1);
      @(negedge i_clk);
    end
    checkOutput("skip end done", o_done, 1);
    checkOutput("skip end playing", o_playing, 0);

    // Rewrite entry 0 while it sounds: only the next pass hears it
    i_loop = 1'b1;
    applyStimulus(1, 3'd1, NOTE_FS4, 8'd1, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0);
    for (int c = 0; c <= 20; c++) begin
      logic [5:0] en;
      logic [2:0] ei;
      if (c < 16)      begin en = song_note(c); ei = song_index(c); end
      else if (c < 19) begin en = NOTE_B4;      ei = 3'd0; end
      else if (c == 19) begin en = NOTE_RST;    ei = 3'd0; end
      else             begin en = NOTE_FS4;     ei = 3'd1; end
      checkOutput($sformatf("rewrite note c%0d", c), o_note, en);
      checkOutput($sformatf("rewrite index c%0d", c), o_index, ei);
      if (c == 2) begin
        i_wr_en = 1'b1; i_wr_addr = 3'd0; i_wr_note = NOTE_B4; i_wr_len = 8'd1;
      end else begin
        i_wr_en = 1'b0;
      end
      @(negedge i_clk);
    end
    applyStimulus(0, 0, 0, 0, 0, 1);
    check_idle("final stop", 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end

endmodule
